// File: rtl/ulx3s_clk_sequencer.sv
// ulx3s_clk_sequencer: qualifies PLL lock, releases per-domain resets in a
// staggered order and generates per-domain clock-enable strobes.
//   clkin      fast PLL output clock (sole clock)
//   resetn     asynchronous active-low reset
//   pll_locked raw PLL lock, asynchronous to clkin
//   div_i      per-channel divide ratio, channel i at [i*DIVW +: DIVW]
//   ce_o       per-channel clock-enable strobe
//   rst_o      per-channel active-high synchronous domain reset
//   ready      all channels released and running
//   lock_lost  saturating count of lock losses after release began
module ulx3s_clk_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int DIVW        = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGGER     = 16
) (
  input  logic                     clkin,
  input  logic                     resetn,
  input  logic                     pll_locked,
  input  logic [CHANNELS*DIVW-1:0] div_i,
  output logic [CHANNELS-1:0]      ce_o,
  output logic [CHANNELS-1:0]      rst_o,
  output logic                     ready,
  output logic [7:0]               lock_lost
);
  localparam int LW    = $clog2(LOCK_CYCLES + 1);
  localparam int RLAST = STAGGER * (CHANNELS - 1);
  localparam int SW    = $clog2(RLAST + 2);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

  state_t              r_state, w_state;
  logic                r_s1, r_lk;
  logic [LW-1:0]       r_stab, w_stab;
  logic [SW-1:0]       r_rel, w_rel;
  logic [CHANNELS-1:0] r_rst, w_rst;
  logic                r_ready, w_ready;
  logic [7:0]          r_lost, w_lost;

  always_ff @(posedge clkin or negedge resetn)
    if (!resetn) begin
      r_s1    <= 1'b0;
      r_lk    <= 1'b0;
      r_state <= WAIT_LOCK;
      r_stab  <= '0;
      r_rel   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
      r_lost  <= '0;
    end else begin
      r_s1    <= pll_locked;
      r_lk    <= r_s1;
      r_state <= w_state;
      r_stab  <= w_stab;
      r_rel   <= w_rel;
      r_rst   <= w_rst;
      r_ready <= w_ready;
      r_lost  <= w_lost;
    end

  // Outputs are registered from the next state, so rst_o[0] drops on the very
  // edge the FSM enters RELEASE; w_rel counts cycles since that entry.
  always_comb begin
    w_state = r_state;
    w_stab  = '0;
    w_rel   = '0;
    w_lost  = r_lost;
    w_rst   = '1;
    case (r_state)
      WAIT_LOCK: w_state = r_lk ? STABLE : WAIT_LOCK;
      STABLE: begin
        if (!r_lk) w_state = WAIT_LOCK;
        else if (r_stab == LW'(LOCK_CYCLES - 1)) w_state = (RLAST == 0) ? RUN : RELEASE;
        else w_stab = r_stab + 1'b1;
      end
      default: begin
        // lock loss takes priority over any stagger terminal count
        if (!r_lk) begin
          w_state = WAIT_LOCK;
          w_lost  = (r_lost == 8'hff) ? r_lost : r_lost + 1'b1;
        end else if (r_state == RELEASE) begin
          w_rel   = r_rel + 1'b1;
          w_state = (int'(w_rel) == RLAST) ? RUN : RELEASE;
        end
      end
    endcase
    for (int i = 0; i < CHANNELS; i++)
      w_rst[i] = (w_state == WAIT_LOCK) || (w_state == STABLE) ||
                 (w_state == RELEASE && int'(w_rel) < STAGGER * i);
    w_ready = (w_state == RUN);
  end

  assign rst_o     = r_rst;
  assign ready     = r_ready;
  assign lock_lost = r_lost;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIVW-1:0] w_d, r_cnt;
    logic            w_term, w_hold, r_ce;
    assign w_d    = div_i[g*DIVW +: DIVW];
    // ">=" rather than "==" so a live shrink of the ratio wraps immediately
    assign w_term = (w_d <= DIVW'(1)) || (r_cnt >= w_d - 1'b1);
    // gating with the next reset too keeps ce_o low on the lock-loss edge
    assign w_hold = r_rst[g] | w_rst[g];
    always_ff @(posedge clkin or negedge resetn)
      if (!resetn) begin
        r_cnt <= '0;
        r_ce  <= 1'b0;
      end else begin
        r_cnt <= (w_hold || w_term) ? '0 : r_cnt + 1'b1;
        r_ce  <= !w_hold && w_term;
      end
    assign ce_o[g] = r_ce;
  end
endmodule

// File: tb/tb_ulx3s_clk_sequencer.sv
// tb_ulx3s_clk_sequencer: directed self-checking bench for ulx3s_clk_sequencer
// with CHANNELS=4, DIVW=8, LOCK_CYCLES=8, STAGGER=4.
module tb_ulx3s_clk_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pll = 1'b0;
  logic [31:0] div = {8'd0, 8'd1, 8'd3, 8'd5};
  logic [3:0]  ce, rst;
  logic        ready;
  logic [7:0]  lost;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ulx3s_clk_sequencer #(.CHANNELS(4), .DIVW(8), .LOCK_CYCLES(8), .STAGGER(4)) dut (
    .clkin(clk), .resetn(resetn), .pll_locked(pll), .div_i(div),
    .ce_o(ce), .rst_o(rst), .ready(ready), .lock_lost(lost)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after edge t0 (first edge sampling pll_locked=1); checks
  // edges t0+1..t0+30 with div = {0,1,3,5}.
  task automatic rel_seq(input string tag, input logic [7:0] exp_lost);
    logic [3:0] er, ec;
    for (int n = 1; n <= 30; n++) begin
      step();
      for (int i = 0; i < 4; i++) er[i] = n < 10 + 4 * i;
      ec[0] = (n >= 15) && ((n - 10) % 5 == 0);
      ec[1] = (n >= 17) && ((n - 14) % 3 == 0);
      ec[2] = n >= 19;
      ec[3] = n >= 23;
      chk($sformatf("%s_rst_t%0d", tag, n), rst, er);
      chk($sformatf("%s_ce_t%0d", tag, n), ce, ec);
      chk($sformatf("%s_ready_t%0d", tag, n), ready, n >= 22);
    end
    chk({tag, "_lost"}, lost, exp_lost);
  endtask

  initial begin
    logic found;
    step(2);
    chk("rst_rst", rst, 4'hf);
    chk("rst_ce", ce, 4'h0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_lost", lost, 8'd0);
    resetn = 1'b1;
    step(3);
    chk("idle_rst", rst, 4'hf);
    // unstable lock: 5 high, 1 low, then high; t0 is the final rise
    pll = 1'b1;
    step(5);
    pll = 1'b0;
    step();
    pll = 1'b1;
    step();
    rel_seq("unstable", 8'd0);
    // lock loss in RUN
    pll = 1'b0;
    step();
    chk("loss_s0_rst", rst, 4'h0);
    step();
    chk("loss_s1_rst", rst, 4'h0);
    step(2);
    chk("loss_s3_rst", rst, 4'hf);
    chk("loss_s3_ce", ce, 4'h0);
    chk("loss_s3_ready", ready, 1'b0);
    chk("loss_s3_lost", lost, 8'd1);
    // clean re-lock repeats the full sequence
    pll = 1'b1;
    step();
    rel_seq("relock", 8'd1);
    // divider shrink 200 -> 4 when cnt_0 = 100
    div[7:0] = 8'd200;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      found = ce[0];
    end
    chk("shrink_pulse_found", found, 1'b1);
    step(100);
    chk("shrink_p100", ce[0], 1'b0);
    div[7:0] = 8'd4;
    step();
    chk("shrink_p101", ce[0], 1'b1);
    for (int k = 102; k <= 104; k++) begin
      step();
      chk($sformatf("shrink_p%0d", k), ce[0], 1'b0);
    end
    step();
    chk("shrink_p105", ce[0], 1'b1);
    step(4);
    chk("shrink_p109", ce[0], 1'b1);
    // saturation: each iteration is one loss after release began
    for (int k = 0; k < 253; k++) begin
      pll = 1'b0;
      step(4);
      pll = 1'b1;
      step(11);
    end
    chk("sat_254", lost, 8'd254);
    pll = 1'b0;
    step(4);
    pll = 1'b1;
    step(11);
    chk("sat_255", lost, 8'd255);
    for (int k = 0; k < 6; k++) begin
      pll = 1'b0;
      step(4);
      pll = 1'b1;
      step(11);
    end
    chk("sat_hold", lost, 8'd255);
    step(2);
    chk("mid_release_rst", rst, 4'he);
    // asynchronous reset mid-RELEASE, no clock edge in between
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst", rst, 4'hf);
    chk("async_ce", ce, 4'h0);
    chk("async_ready", ready, 1'b0);
    chk("async_lost", lost, 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
